load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-stage load/store unit for the RISC-V core. It sits directly downstream of the ALU and takes the ALU result as the effective address of a load or store. It issues one word-aligned data-memory request with byte enables, waits for the memory handshake, then returns sign- or zero-extended load data and a one-cycle completion pulse to writeback. It stalls the core while a request is in flight and times out if memory never responds.

Parameters:
TIMEOUT, 16, number of ACCESS cycles to wait for mem_ready before reporting a bus error (minimum 1)

Ports:
clk  input  1  core clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request strobe; sampled only in IDLE
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3 (size/sign)
req_addr  input  32  effective address (ALU result)
req_wdata  input  32  store data (rs2)
busy  output  1  high whenever state is not IDLE; core stall
done  output  1  one-cycle completion pulse
load_data  output  32  extended load result; valid while done=1
err_code  output  2  00 ok, 01 misaligned, 10 bus timeout, 11 illegal funct3; valid while done=1
mem_req  output  1  memory request, held until accepted or timed out
mem_we  output  1  write enable
mem_addr  output  32  word address; {req_addr[31:2], 2'b00}
mem_wdata  output  32  lane-replicated store data
mem_be  output  4  byte enables
mem_ready  input  1  memory accept; read data valid in the same cycle
mem_rdata  input  32  read data

Behaviour:
- Reset: state IDLE. busy, done, load_data, err_code, mem_req, mem_we, mem_addr, mem_wdata, mem_be, and the timeout counter all clear to 0.
- All outputs are registered.
- States: IDLE, ACCESS, RESP.
- IDLE + req_valid: latch the request fields.
  - Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Legal funct3 for stores: 000 SB, 001 SH, 010 SW.
  - Illegal funct3: go to RESP with err 11.
  - Misaligned (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): go to RESP with err 01.
  - Otherwise: go to ACCESS. mem_req=1 and mem_addr/mem_we/mem_be/mem_wdata are driven from the next cycle; the counter clears.
  - Error checks have priority illegal funct3 > misaligned. No memory access occurs on any error.
- ACCESS:
  - mem_ready=1: capture and extend mem_rdata (loads), then go to RESP with err 00; mem_req drops the next cycle.
  - Otherwise, counter == TIMEOUT-1: go to RESP with err 10 and drop mem_req.
  - Otherwise: increment the counter and hold all mem_* outputs stable.
  - mem_ready in the final timeout cycle counts as success (ready wins).
- RESP: done=1 for exactly one cycle, then IDLE.
  - req_valid in RESP or ACCESS is ignored; the core must hold the request until busy falls.
- Latency: request accepted at edge N.
  - Error responses: done during cycle N+1.
  - Memory access: mem_req from N+1; with mem_ready in the first ACCESS cycle, done during N+2. Each extra wait cycle adds 1.
- Byte enables (lane = addr[1:0]):
  - Byte access: 0001 << lane.
  - Half access: 0011 << (2*addr[1]).
  - Word access: 1111.
  - Applied to both loads and stores.
- Store data:
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- Load extension:
  - LB/LBU: select byte rdata[8*lane+7:8*lane].
  - LH/LHU: select half rdata[16*addr[1]+15:16*addr[1]].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - load_data = 0 on stores and on every error response.
- Idle bus values:
  - While mem_req=0: mem_we=0 and mem_be=0; mem_addr and mem_wdata hold their last values.
  - mem_ready while mem_req=0 is ignored.
- Reset mid-operation: rst in ACCESS or RESP returns to IDLE at that edge. mem_req drops, no done pulse is produced, and all outputs go to their reset values.

Test Plan:
1. LW, addr 0x100; mem_ready after 2 wait cycles with rdata 0xDEADBEEF -> mem_addr 0x100, be 1111, we 0; mem_req high for 3 cycles; then a single done, load_data 0xDEADBEEF, err 00.
2. rdata 0x80123456:
   - LB @0x103 -> 0xFFFFFF80, be 1000.
   - LBU @0x103 -> 0x00000080.
   - LH @0x102 -> 0xFFFF8012, be 1100.
   - LHU @0x102 -> 0x00008012.
   - LB @0x100 -> 0x00000056.
3. Stores:
   - SB @0x201, wdata 0x000000AB -> mem_addr 0x200, be 0010, wdata 0xABABABAB, we 1.
   - SH @0x202, wdata 0x00001234 -> be 1100, wdata 0x12341234.
   - In both cases load_data=0 at done.
4. Error responses:
   - LW @0x102 -> no mem_req; done in cycle N+1 with err 01.
   - LH @0x101 -> err 01.
   - Load funct3 011 -> err 11.
   - Store funct3 100 -> err 11.
5. Timeout with TIMEOUT=16:
   - mem_ready held 0 -> mem_req high for exactly 16 cycles, then done with err 10, load_data 0.
   - Repeat with mem_ready asserted in the 16th cycle -> err 00.
6. Control corner cases:
   - rst asserted in the 2nd ACCESS cycle -> next cycle mem_req=0, busy=0, and no done ever appears.
   - req_valid pulsed while busy -> no second access.
   - Back-to-back requests issued the cycle after done -> both complete in order.

Source files
------------

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: one aligned data-memory access per request,
// with byte enables, lane-replicated store data, load extension and a bus timeout.
//
// state  | meaning
// IDLE   | waiting for req_valid; bus idle
// ACCESS | mem_req held until mem_ready or timeout
// RESP   | done pulse with load_data / err_code
module load_store_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic [1:0]  err_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_FUNCT3  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t          r_state,     w_state_n;
  logic [CW-1:0]   r_count,     w_count_n;
  logic            r_we,        w_we_n;
  logic [2:0]      r_funct3,    w_funct3_n;
  logic [1:0]      r_lane,      w_lane_n;
  logic            r_busy,      w_busy_n;
  logic            r_done,      w_done_n;
  logic [31:0]     r_load_data, w_load_data_n;
  logic [1:0]      r_err,       w_err_n;
  logic            r_mem_req,   w_mem_req_n;
  logic            r_mem_we,    w_mem_we_n;
  logic [31:0]     r_mem_addr,  w_mem_addr_n;
  logic [31:0]     r_mem_wdata, w_mem_wdata_n;
  logic [3:0]      r_mem_be,    w_mem_be_n;

  logic            w_illegal;
  logic            w_misaligned;
  logic [3:0]      w_be;
  logic [31:0]     w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_ext;

  // Request decode, evaluated on the live request inputs while IDLE.
  always_comb begin
    if (req_we)
      w_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
    else
      w_illegal = (req_funct3[1:0] == 2'b11) | (req_funct3 == 3'b110);

    w_misaligned = ((req_funct3[1:0] == 2'b01) & req_addr[0]) |
                   ((req_funct3[1:0] == 2'b10) & (req_addr[1:0] != 2'b00));

    w_be    = 4'b1111;
    w_wdata = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
      end
    endcase
  end

  // Lane select and extension of the returned word, using the latched request.
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = mem_rdata[7:0];
      2'd1:    w_byte = mem_rdata[15:8];
      2'd2:    w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (r_funct3)
      3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_ext = {{16{w_half[15]}}, w_half};
      3'b100:  w_ext = {24'd0, w_byte};
      3'b101:  w_ext = {16'd0, w_half};
      default: w_ext = mem_rdata;
    endcase
    if (r_we)
      w_ext = 32'd0;
  end

  always_comb begin
    w_state_n     = r_state;
    w_count_n     = r_count;
    w_we_n        = r_we;
    w_funct3_n    = r_funct3;
    w_lane_n      = r_lane;
    w_busy_n      = r_busy;
    w_done_n      = 1'b0;
    w_load_data_n = r_load_data;
    w_err_n       = r_err;
    w_mem_req_n   = r_mem_req;
    w_mem_we_n    = r_mem_we;
    w_mem_addr_n  = r_mem_addr;
    w_mem_wdata_n = r_mem_wdata;
    w_mem_be_n    = r_mem_be;

    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_we_n     = req_we;
          w_funct3_n = req_funct3;
          w_lane_n   = req_addr[1:0];
          w_busy_n   = 1'b1;
          if (w_illegal) begin
            w_state_n     = S_RESP;
            w_done_n      = 1'b1;
            w_err_n       = ERR_FUNCT3;
            w_load_data_n = 32'd0;
          end else if (w_misaligned) begin
            w_state_n     = S_RESP;
            w_done_n      = 1'b1;
            w_err_n       = ERR_ALIGN;
            w_load_data_n = 32'd0;
          end else begin
            w_state_n     = S_ACCESS;
            w_count_n     = '0;
            w_mem_req_n   = 1'b1;
            w_mem_we_n    = req_we;
            w_mem_addr_n  = {req_addr[31:2], 2'b00};
            w_mem_wdata_n = w_wdata;
            w_mem_be_n    = w_be;
          end
        end
      end

      S_ACCESS: begin
        // mem_ready is checked first so a response in the last allowed cycle succeeds.
        if (mem_ready) begin
          w_state_n     = S_RESP;
          w_done_n      = 1'b1;
          w_err_n       = ERR_OK;
          w_load_data_n = w_ext;
          w_mem_req_n   = 1'b0;
          w_mem_we_n    = 1'b0;
          w_mem_be_n    = 4'b0000;
        end else if (r_count == LAST_CNT) begin
          w_state_n     = S_RESP;
          w_done_n      = 1'b1;
          w_err_n       = ERR_TIMEOUT;
          w_load_data_n = 32'd0;
          w_mem_req_n   = 1'b0;
          w_mem_we_n    = 1'b0;
          w_mem_be_n    = 4'b0000;
        end else begin
          w_count_n = r_count + 1'b1;
        end
      end

      S_RESP: begin
        w_state_n = S_IDLE;
        w_busy_n  = 1'b0;
      end

      default: begin
        w_state_n   = S_IDLE;
        w_busy_n    = 1'b0;
        w_mem_req_n = 1'b0;
        w_mem_we_n  = 1'b0;
        w_mem_be_n  = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_lane      <= 2'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_load_data <= 32'd0;
      r_err       <= 2'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_be    <= 4'd0;
    end else begin
      r_state     <= w_state_n;
      r_count     <= w_count_n;
      r_we        <= w_we_n;
      r_funct3    <= w_funct3_n;
      r_lane      <= w_lane_n;
      r_busy      <= w_busy_n;
      r_done      <= w_done_n;
      r_load_data <= w_load_data_n;
      r_err       <= w_err_n;
      r_mem_req   <= w_mem_req_n;
      r_mem_we    <= w_mem_we_n;
      r_mem_addr  <= w_mem_addr_n;
      r_mem_wdata <= w_mem_wdata_n;
      r_mem_be    <= w_mem_be_n;
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign load_data = r_load_data;
  assign err_code  = r_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: transaction-level reference model, per-cycle compare,
// directed cases from the test plan and randomized traffic.
module tb_load_store_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        busy, done, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [1:0]  err_code;
  logic [3:0]  mem_be;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy), .done(done), .load_data(load_data), .err_code(err_code),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected transaction, set by the driver; e_acc is the first sample after the accept edge.
  bit          chk_en = 1'b0;
  bit          e_access = 1'b0;
  bit          e_we = 1'b0;
  int          e_acc = -1000;
  int          e_nacc = 0;
  int          e_kill = 1 << 30;
  logic [31:0] e_addr = 0, e_wdata = 0, e_ld = 0;
  logic [3:0]  e_be = 0;
  logic [1:0]  e_err = 0;

  // What the DUT actually did during the latest transaction.
  int          c_req = 0, c_done = 0;
  logic [31:0] c_ld = 0, c_addr = 0, c_wd = 0;
  logic [3:0]  c_be = 0;
  logic [1:0]  c_err = 0;
  logic        c_we = 0;

  function automatic void model(input bit we, input bit [2:0] f3, input bit [31:0] a,
                                input bit [31:0] wd, input bit [31:0] rd,
                                output bit acc, output bit [1:0] err, output bit [3:0] be,
                                output bit [31:0] wrep, output bit [31:0] ld);
    int nb, off;
    bit illegal;
    bit [31:0] mask, v;
    if (we) illegal = (f3 > 3'd2);
    else    illegal = !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    nb  = 1 << f3[1:0];
    off = int'(a & 32'd3);
    acc = 0; err = 0; be = 0; wrep = 0; ld = 0;
    if (illegal) err = 2'd3;
    else if ((off % nb) != 0) err = 2'd1;
    else begin
      acc  = 1;
      be   = 4'(((1 << nb) - 1) << off);
      wrep = (nb == 1) ? wd[7:0] * 32'h01010101 : (nb == 2) ? wd[15:0] * 32'h00010001 : wd;
      if (!we) begin
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        v = (rd >> (8 * off)) & mask;
        if (!f3[2] && nb < 4 && v[8 * nb - 1]) v = v | ~mask;
        ld = v;
      end
    end
  endfunction

  always @(negedge clk) begin
    int rel, resp;
    bit acc_now, resp_now;
    if (chk_en) begin
      rel      = cyc - e_acc;
      resp     = e_access ? e_nacc : 0;
      acc_now  = e_access && rel >= 0 && rel < e_nacc && cyc < e_kill;
      resp_now = (rel == resp) && cyc < e_kill;
      chk("busy", busy, acc_now || resp_now);
      chk("done", done, resp_now);
      chk("mem_req", mem_req, acc_now);
      chk("mem_we", mem_we, acc_now ? e_we : 1'b0);
      chk("mem_be", mem_be, acc_now ? e_be : 4'd0);
      if (acc_now) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wdata", mem_wdata, e_wdata);
      end
      if (resp_now) begin
        chk("load_data", load_data, e_ld);
        chk("err_code", err_code, e_err);
      end
      if (cyc == e_kill) begin
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_err_code", err_code, 32'd0);
      end
      if (mem_req === 1'b1) begin
        c_req++;
        c_addr = mem_addr; c_wd = mem_wdata; c_be = mem_be; c_we = mem_we;
      end
      if (done === 1'b1) begin
        c_done++;
        c_ld = load_data; c_err = err_code;
      end
    end
  end

  // Issue one request at a negedge and run it to completion; w = wait cycles before mem_ready.
  task automatic run(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                     input bit [31:0] rd, input int w, input bit poke);
    bit acc;
    bit [1:0] err;
    bit [3:0] be;
    bit [31:0] wrep, ld;
    int resp;
    model(we, f3, a, wd, rd, acc, err, be, wrep, ld);
    e_access = acc; e_we = we; e_addr = {a[31:2], 2'b00}; e_wdata = wrep;
    e_be = be; e_err = err; e_ld = ld;
    if (acc && w >= TIMEOUT) begin
      e_err = 2'd2; e_ld = 32'd0; e_nacc = TIMEOUT;
    end else begin
      e_nacc = w + 1;
    end
    e_acc = cyc + 1;
    e_kill = 1 << 30;
    c_req = 0; c_done = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    resp = acc ? e_nacc : 0;
    @(negedge clk);
    for (int r = 0; r <= resp; r++) begin
      req_valid = poke && r == 1 && r < resp;
      if (req_valid) begin
        req_we = 1'($urandom); req_funct3 = 3'd2;
        req_addr = $urandom & 32'hFFFF_FFFC; req_wdata = $urandom;
      end
      if (acc && r < e_nacc) begin
        mem_ready = (r == w);
        mem_rdata = (r == w) ? rd : $urandom;
      end else begin
        mem_ready = 1'($urandom);
        mem_rdata = $urandom;
      end
      @(negedge clk);
    end
  endtask

  task automatic rst_mid();
    e_access = 1; e_we = 0; e_addr = 32'h300; e_wdata = 32'h5555AAAA;
    e_be = 4'hF; e_err = 2'd2; e_ld = 0; e_nacc = TIMEOUT;
    e_acc = cyc + 1; e_kill = cyc + 3;
    c_req = 0; c_done = 0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300; req_wdata = 32'h5555AAAA;
    @(negedge clk);
    req_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) begin
      mem_ready = 1'($urandom); mem_rdata = $urandom;
      @(negedge clk);
    end
    chk("rst_mid_req_cycles", c_req, 2);
    chk("rst_mid_no_done", c_done, 0);
  endtask

  initial begin
    int sel, w;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_mem_be", mem_be, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
    chk("reset_load_data", load_data, 0);
    chk("reset_err_code", err_code, 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    run(0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 2, 0);
    chk("t1_req_cycles", c_req, 3);
    chk("t1_done_count", c_done, 1);
    chk("t1_addr", c_addr, 32'h100);
    chk("t1_be", c_be, 4'b1111);
    chk("t1_we", c_we, 0);
    chk("t1_load", c_ld, 32'hDEADBEEF);
    chk("t1_err", c_err, 0);

    run(0, 3'd0, 32'h103, 0, 32'h80123456, 0, 0);
    chk("lb103_load", c_ld, 32'hFFFFFF80);
    chk("lb103_be", c_be, 4'b1000);
    run(0, 3'd4, 32'h103, 0, 32'h80123456, 1, 0);
    chk("lbu103_load", c_ld, 32'h00000080);
    run(0, 3'd1, 32'h102, 0, 32'h80123456, 0, 0);
    chk("lh102_load", c_ld, 32'hFFFF8012);
    chk("lh102_be", c_be, 4'b1100);
    run(0, 3'd5, 32'h102, 0, 32'h80123456, 0, 0);
    chk("lhu102_load", c_ld, 32'h00008012);
    run(0, 3'd0, 32'h100, 0, 32'h80123456, 0, 0);
    chk("lb100_load", c_ld, 32'h00000056);

    run(1, 3'd0, 32'h201, 32'h000000AB, 32'h12345678, 1, 0);
    chk("sb_addr", c_addr, 32'h200);
    chk("sb_be", c_be, 4'b0010);
    chk("sb_wdata", c_wd, 32'hABABABAB);
    chk("sb_we", c_we, 1);
    chk("sb_load", c_ld, 0);
    run(1, 3'd1, 32'h202, 32'h00001234, 32'h12345678, 0, 0);
    chk("sh_be", c_be, 4'b1100);
    chk("sh_wdata", c_wd, 32'h12341234);
    chk("sh_load", c_ld, 0);

    run(0, 3'd2, 32'h102, 0, 0, 0, 0);
    chk("lw_mis_req", c_req, 0);
    chk("lw_mis_err", c_err, 1);
    run(0, 3'd1, 32'h101, 0, 0, 0, 0);
    chk("lh_mis_err", c_err, 1);
    run(0, 3'd3, 32'h100, 0, 0, 0, 0);
    chk("ld_f3_011_err", c_err, 3);
    run(1, 3'd4, 32'h101, 0, 0, 0, 0);
    chk("st_f3_100_err", c_err, 3);
    chk("st_f3_100_req", c_req, 0);

    run(0, 3'd2, 32'h400, 0, 32'h11111111, 100, 0);
    chk("timeout_req_cycles", c_req, 16);
    chk("timeout_err", c_err, 2);
    chk("timeout_load", c_ld, 0);
    run(0, 3'd2, 32'h400, 0, 32'h0BADF00D, 15, 0);
    chk("last_cycle_req_cycles", c_req, 16);
    chk("last_cycle_err", c_err, 0);
    chk("last_cycle_load", c_ld, 32'h0BADF00D);

    rst_mid();

    run(0, 3'd2, 32'h500, 0, 32'h11112222, 3, 1);
    chk("poke_req_cycles", c_req, 4);
    chk("poke_done_count", c_done, 1);
    run(1, 3'd2, 32'h600, 32'hCAFEBABE, 0, 0, 0);
    chk("b2b_first_wdata", c_wd, 32'hCAFEBABE);
    run(0, 3'd0, 32'h601, 0, 32'h0000AA00, 0, 0);
    chk("b2b_second_load", c_ld, 32'hFFFFFFAA);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)       w = $urandom_range(0, 3);
      else if (sel == 7) w = TIMEOUT - 1;
      else if (sel == 8) w = TIMEOUT + $urandom_range(0, 5);
      else               w = $urandom_range(4, 14);
      run(1'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
          $urandom, $urandom, w, $urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) begin
        mem_ready = 1'($urandom); mem_rdata = $urandom;
        @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
